// File: rtl/vga_sync_gen_if.sv
// Pixel-fetch bus between the VGA timing stage and its pattern/framebuffer source.
// pix_rgb answers a pix_req one sys_clk cycle later.
interface vga_sync_gen_if;
   logic        pix_req;
   logic [9:0]  pix_x;
   logic [9:0]  pix_y;
   logic [11:0] pix_rgb;

   modport master (output pix_req, output pix_x, output pix_y, input pix_rgb);
   modport slave  (input pix_req, input pix_x, input pix_y, output pix_rgb);
endinterface

// File: rtl/vga_sync_gen.sv
// VGA timing and pixel-fetch stage: pixel-tick divider, h/v counters, pixel request,
// and registered, mutually aligned h_sync / v_sync / pixel_data.
module vga_sync_gen #(
   parameter int unsigned CLK_DIV  = 4,
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter bit          SYNC_POL = 1'b0
) (
   input  logic            sys_clk,
   input  logic            sys_rst_n,
   vga_sync_gen_if.master  pix,
   output logic            frame_start,
   output logic            h_sync,
   output logic            v_sync,
   output logic [11:0]     pixel_data
);

   localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
   localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
   localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
   localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;
   localparam int unsigned DIV_W        = $clog2(CLK_DIV);
   localparam int unsigned H_W          = $clog2(H_TOTAL);
   localparam int unsigned V_W          = $clog2(V_TOTAL);

   logic [DIV_W-1:0] div_cnt;
   logic [H_W-1:0]   h_cnt;
   logic [V_W-1:0]   v_cnt;
   logic             tick;
   logic             h_end;
   logic             v_end;
   logic             h_act_c;
   logic             v_act_c;
   logic             h_in_sync_c;
   logic             v_in_sync_c;

   // stage-1 snapshot of the pixel just requested, held until the next tick
   logic             s1_strb;
   logic             s1_act;
   logic             s1_hs;
   logic             s1_vs;
   // high on the cycle the source's answer is on pix_rgb
   logic             fetch_strb;

   assign tick  = (div_cnt == DIV_W'(CLK_DIV - 1));
   assign h_end = (32'(h_cnt) == H_TOTAL - 1);
   assign v_end = (32'(v_cnt) == V_TOTAL - 1);

   // Region decode of the current counter position
   always_comb begin
      h_act_c     = 1'b0;
      v_act_c     = 1'b0;
      h_in_sync_c = 1'b0;
      v_in_sync_c = 1'b0;
      if (32'(h_cnt) < H_ACTIVE) h_act_c = 1'b1;
      if (32'(v_cnt) < V_ACTIVE) v_act_c = 1'b1;
      if ((32'(h_cnt) >= H_SYNC_START) && (32'(h_cnt) < H_SYNC_END)) h_in_sync_c = 1'b1;
      if ((32'(v_cnt) >= V_SYNC_START) && (32'(v_cnt) < V_SYNC_END)) v_in_sync_c = 1'b1;
   end

   // Pixel-tick divider and raster counters
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         div_cnt <= '0;
         h_cnt   <= '0;
         v_cnt   <= '0;
      end else begin
         div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
         if (tick) begin
            if (h_end) begin
               h_cnt <= '0;
               v_cnt <= v_end ? '0 : v_cnt + V_W'(1);
            end else begin
               h_cnt <= h_cnt + H_W'(1);
            end
         end
      end
   end

   // Stage 1: pixel request, coordinates, frame marker and region snapshot
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         pix.pix_req <= 1'b0;
         pix.pix_x   <= '0;
         pix.pix_y   <= '0;
         frame_start <= 1'b0;
         s1_strb     <= 1'b0;
         s1_act      <= 1'b0;
         s1_hs       <= ~SYNC_POL;
         s1_vs       <= ~SYNC_POL;
      end else begin
         pix.pix_req <= tick & h_act_c & v_act_c;
         frame_start <= tick & (h_cnt == '0) & (v_cnt == '0);
         s1_strb     <= tick;
         if (tick) begin
            pix.pix_x <= 10'(h_cnt);
            pix.pix_y <= 10'(v_cnt);
            s1_act    <= h_act_c & v_act_c;
            s1_hs     <= h_in_sync_c ? SYNC_POL : ~SYNC_POL;
            s1_vs     <= v_in_sync_c ? SYNC_POL : ~SYNC_POL;
         end
      end
   end

   // Stage 2: capture source data and launch syncs together so all pin edges align
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         fetch_strb <= 1'b0;
         pixel_data <= '0;
         h_sync     <= ~SYNC_POL;
         v_sync     <= ~SYNC_POL;
      end else begin
         fetch_strb <= s1_strb;
         if (fetch_strb) begin
            pixel_data <= s1_act ? pix.pix_rgb : 12'h000;
            h_sync     <= s1_hs;
            v_sync     <= s1_vs;
         end
      end
   end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen on a reduced raster (H 4/1/1/1, V 3/1/1/1), two divider/polarity variants,
// against a closed-form timing model plus a hand-derived vector table.
module tb_vga_sync_gen;

   localparam int HA = 4, HF = 1, HS = 1, HB = 1;
   localparam int VA = 3, VF = 1, VS = 1, VB = 1;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int D0 = 2;
   localparam int D1 = 3;
   localparam int TR_N = 260;

   typedef struct packed {
      logic        req;
      logic [9:0]  x;
      logic [9:0]  y;
      logic        fs;
      logic        hs;
      logic        vs;
      logic [11:0] data;
   } exp_t;

   typedef struct {
      int   k;
      exp_t e;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   vga_sync_gen_if bus0 ();
   vga_sync_gen_if bus1 ();
   logic        fs0, hs0, vs0, fs1, hs1, vs1;
   logic [11:0] pd0, pd1;

   vga_sync_gen #(.CLK_DIV(D0), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                  .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0))
      u_dut0 (.sys_clk(clk), .sys_rst_n(rst_n), .pix(bus0.master), .frame_start(fs0),
              .h_sync(hs0), .v_sync(vs0), .pixel_data(pd0));

   vga_sync_gen #(.CLK_DIV(D1), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                  .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b1))
      u_dut1 (.sys_clk(clk), .sys_rst_n(rst_n), .pix(bus1.master), .frame_start(fs1),
              .h_sync(hs1), .v_sync(vs1), .pixel_data(pd1));

   function automatic logic [11:0] src_rgb(input logic [9:0] x, input logic [9:0] y);
      logic [21:0] w;
      w = {2'b00, y, x};
      return w[11:0];
   endfunction

   // Pixel sources: answer a request next cycle, otherwise drive junk that must be ignored
   always @(posedge clk) begin
      bus0.pix_rgb <= bus0.pix_req ? src_rgb(bus0.pix_x, bus0.pix_y) : 12'($urandom);
      bus1.pix_rgb <= bus1.pix_req ? src_rgb(bus1.pix_x, bus1.pix_y) : 12'($urandom);
   end

   int n_cmp = 0;
   int n_bad = 0;
   exp_t q0[$];
   exp_t q1[$];
   exp_t trace [0:TR_N];
   vec_t tab [16];

   function automatic exp_t mk(input logic req, input int x, input int y, input logic fs,
                               input logic hs, input logic vs, input logic [11:0] data);
      exp_t e;
      e.req = req; e.x = 10'(x); e.y = 10'(y); e.fs = fs; e.hs = hs; e.vs = vs; e.data = data;
      return e;
   endfunction

   // Expected pins after k rising edges since reset release, from absolute pixel numbering
   function automatic exp_t model(input int k, input int d, input logic pol);
      exp_t e;
      int p, h, v;
      logic act;
      e = mk(1'b0, 0, 0, 1'b0, ~pol, ~pol, 12'h000);
      if (k >= d) begin
         p = (k - d) / d;
         h = p % HT;
         v = (p / HT) % VT;
         e.x = 10'(h);
         e.y = 10'(v);
         if (k % d == 0) begin
            e.req = (h < HA) && (v < VA);
            e.fs  = (h == 0) && (v == 0);
         end
      end
      if (k >= d + 2) begin
         p = (k - d - 2) / d;
         h = p % HT;
         v = (p / HT) % VT;
         act = (h < HA) && (v < VA);
         e.data = act ? src_rgb(10'(h), 10'(v)) : 12'h000;
         e.hs = ((h >= HA + HF) && (h < HA + HF + HS)) ? pol : ~pol;
         e.vs = ((v >= VA + VF) && (v < VA + VF + VS)) ? pol : ~pol;
      end
      return e;
   endfunction

   function automatic exp_t snap0();
      return mk(bus0.pix_req, int'(bus0.pix_x), int'(bus0.pix_y), fs0, hs0, vs0, pd0);
   endfunction

   function automatic exp_t snap1();
      return mk(bus1.pix_req, int'(bus1.pix_x), int'(bus1.pix_y), fs1, hs1, vs1, pd1);
   endfunction

   task automatic check(input string nm, input int k, input exp_t a, input exp_t e);
      n_cmp++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s k=%0d got req=%b x=%0d y=%0d fs=%b hs=%b vs=%b data=%h want req=%b x=%0d y=%0d fs=%b hs=%b vs=%b data=%h",
                  nm, k, a.req, a.x, a.y, a.fs, a.hs, a.vs, a.data,
                  e.req, e.x, e.y, e.fs, e.hs, e.vs, e.data);
      end
   endtask

   // Release reset at a falling edge, then compare both instances every cycle via the scoreboard
   task automatic run(input int n, input bit rec);
      exp_t e, a;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      a = snap0();
      if (rec) trace[0] = a;
      check("dut0", 0, a, model(0, D0, 1'b0));
      check("dut1", 0, snap1(), model(0, D1, 1'b1));
      for (int k = 1; k <= n; k++) begin
         @(posedge clk);
         q0.push_back(model(k, D0, 1'b0));
         q1.push_back(model(k, D1, 1'b1));
         @(negedge clk);
         a = snap0();
         if (rec && k <= TR_N) trace[k] = a;
         e = q0.pop_front();
         check("dut0", k, a, e);
         e = q1.pop_front();
         check("dut1", k, snap1(), e);
      end
   endtask

   initial begin
      tab[0]  = '{0,  mk(1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 12'h000)};
      tab[1]  = '{1,  mk(1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 12'h000)};
      tab[2]  = '{2,  mk(1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 12'h000)};
      tab[3]  = '{3,  mk(1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 12'h000)};
      tab[4]  = '{6,  mk(1'b1, 2, 0, 1'b0, 1'b1, 1'b1, 12'h001)};
      tab[5]  = '{10, mk(1'b0, 4, 0, 1'b0, 1'b1, 1'b1, 12'h003)};
      tab[6]  = '{14, mk(1'b0, 6, 0, 1'b0, 1'b0, 1'b1, 12'h000)};
      tab[7]  = '{20, mk(1'b1, 2, 1, 1'b0, 1'b1, 1'b1, 12'h401)};
      tab[8]  = '{22, mk(1'b1, 3, 1, 1'b0, 1'b1, 1'b1, 12'h402)};
      tab[9]  = '{38, mk(1'b0, 4, 2, 1'b0, 1'b1, 1'b1, 12'h803)};
      tab[10] = '{44, mk(1'b0, 0, 3, 1'b0, 1'b1, 1'b1, 12'h000)};
      tab[11] = '{60, mk(1'b0, 1, 4, 1'b0, 1'b1, 1'b0, 12'h000)};
      tab[12] = '{70, mk(1'b0, 6, 4, 1'b0, 1'b0, 1'b0, 12'h000)};
      tab[13] = '{74, mk(1'b0, 1, 5, 1'b0, 1'b1, 1'b1, 12'h000)};
      tab[14] = '{86, mk(1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 12'h000)};
      tab[15] = '{90, mk(1'b1, 2, 0, 1'b0, 1'b1, 1'b1, 12'h001)};

      // Outputs sit at reset values while reset is held
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("rst_hold0", i, snap0(), model(0, D0, 1'b0));
         check("rst_hold1", i, snap1(), model(0, D1, 1'b1));
      end

      // Three-plus frames of free-running timing
      run(TR_N, 1'b1);

      // Hand-derived milestones for the CLK_DIV=2, active-low instance
      for (int i = 0; i < 16; i++)
         check("table", tab[i].k, trace[tab[i].k], tab[i].e);

      // Reset in the middle of an active line clears everything without waiting for a clock
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst0", -1, snap0(), model(0, D0, 1'b0));
      check("async_rst1", -1, snap1(), model(0, D1, 1'b1));
      repeat (3) @(posedge clk);

      // Restart from pixel (0,0) and keep the raster periods after release
      run(300, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
